// File: rtl/booth_divider_nbit.sv
// Sequential signed restoring divider: WAIT -> CAL (WIDTH iterations on magnitudes) -> FINISH.
// Optional macro DIVIDER_DBZ_FLAG_EN adds a dbz output and a one-cycle divide-by-zero path.
module booth_divider_nbit #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] q,
    output logic signed [WIDTH-1:0] r,
    output logic                    busy,
    output logic                    done
`ifdef DIVIDER_DBZ_FLAG_EN
    ,
    output logic                    dbz
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_WAIT   = 2'b00,
        S_CAL    = 2'b01,
        S_FINISH = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] babs_q, babs_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic [WIDTH:0]   rem_sh;
`ifdef DIVIDER_DBZ_FLAG_EN
    logic             dbz_q, dbz_d;
`endif

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        // -(-2^(W-1)) keeps its bit pattern, which reads correctly as an unsigned magnitude
        return v[WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] m);
        return neg ? -m : m;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        babs_d   = babs_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        rem_sh   = '0;
`ifdef DIVIDER_DBZ_FLAG_EN
        dbz_d    = dbz_q;
`endif
        case (state_q)
            S_WAIT: begin
                if (start) begin
                    babs_d   = mag(b);
                    quo_d    = mag(a);
                    rem_d    = '0;
                    sign_q_d = a[WIDTH-1] ^ b[WIDTH-1];
                    sign_r_d = a[WIDTH-1];
                    cnt_d    = CW'(WIDTH - 1);
                    state_d  = S_CAL;
`ifdef DIVIDER_DBZ_FLAG_EN
                    dbz_d    = (b == '0);
                    if (b == '0) begin
                        quo_d   = '0;
                        rem_d   = mag(a);
                        state_d = S_FINISH;
                    end
`endif
                end
            end
            S_CAL: begin
                // partial remainder is widened by one bit only for the compare/subtract
                rem_sh = {rem_q, quo_q[WIDTH-1]};
                if (rem_sh >= {1'b0, babs_q}) begin
                    rem_d = WIDTH'(rem_sh - {1'b0, babs_q});
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_WAIT;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            babs_q   <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
`ifdef DIVIDER_DBZ_FLAG_EN
            dbz_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            babs_q   <= babs_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
`ifdef DIVIDER_DBZ_FLAG_EN
            dbz_q    <= dbz_d;
`endif
        end
    end

    always_comb begin
        busy = (state_q != S_WAIT);
        done = (state_q == S_FINISH);
        q    = '0;
        r    = '0;
        if (done) begin
            q = apply_sign(sign_q_q, quo_q);
            r = apply_sign(sign_r_q, rem_q);
        end
`ifdef DIVIDER_DBZ_FLAG_EN
        dbz = done & dbz_q;
`endif
    end

endmodule
